pe_pkt_gen: RTL and testbench
=============================

Name: pe_pkt_gen

Overview:
- Clocked packetizer that sits directly upstream of the PE depacketizer on the NoC path.
- Accepts filter-row words and ifmap-row words from the memory/source node through two independent valid/ready channels.
- Arbitrates between them round-robin, builds 33-bit NoC packets with type, destination and source header, and emits one packet at a time on a valid/ready output.
- A programmable inter-packet gap throttles injection into the router.

Parameters:
- WIDTH, 33, packet width.
- FILTER_WIDTH, 8, bits per filter weight; three weights per packet.
- IFMAP_WIDTH, 1, bits per ifmap element; nine elements per packet.
- SRC_ADDR, 4'b0000, this node's address, inserted in packet [27:24].
- GAP, 1, idle cycles forced after each output handshake (0..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- filt_valid  in  1  filter word valid
- filt_ready  out  1  filter word accepted this cycle
- filt_data  in  3*FILTER_WIDTH  weights: w0 [7:0], w1 [15:8], w2 [23:16]
- filt_dest  in  4  destination PE address for the filter word
- ifmap_valid  in  1  ifmap word valid
- ifmap_ready  out  1  ifmap word accepted this cycle
- ifmap_data  in  9*IFMAP_WIDTH  ifmap rows: [2:0], [5:3], [8:6]
- ifmap_dest  in  4  destination PE address for the ifmap word
- pkt_valid  out  1  packet valid
- pkt_ready  in  1  downstream accepts packet
- pkt_data  out  WIDTH  packet
- pkt_count  out  16  number of packets sent; wraps at 2^16

Behaviour:
- Packet format:
  - [32] type: 1 = ifmap, 0 = filter.
  - [31:28] dest; [27:24] SRC_ADDR.
  - Filter payload: [23:0] = filt_data.
  - Ifmap payload: [8:0] = ifmap_data, [23:9] = 0.
- FSM states: IDLE, SEND, GAP.
- Reset (async, rst_n=0):
  - state=IDLE; pkt_valid=0; pkt_data=0; pkt_count=0; gap counter=0.
  - last_grant=IFMAP, so filter wins the first tie.
  - filt_ready=0 and ifmap_ready=0 while rst_n=0.
- IDLE:
  - Ready outputs are combinational.
  - filt_ready = filt_valid & (!ifmap_valid | last_grant==IFMAP).
  - ifmap_ready = ifmap_valid & (!filt_valid | last_grant==FILTER).
  - At most one ready is high in a cycle.
  - On a handshake, register the packet into pkt_data, set pkt_valid=1, update last_grant, and go to SEND.
  - Latency: handshake in cycle N gives pkt_valid=1 from cycle N+1.
- SEND:
  - Both readies are 0; pkt_valid and pkt_data are held stable until pkt_valid & pkt_ready.
  - On the output handshake: pkt_count+1 (wraps 0xFFFF→0x0000) and pkt_valid=0 next cycle.
  - Next state is GAP with counter=GAP, or IDLE if GAP==0.
- GAP:
  - Both readies are 0; the counter decrements each cycle; go to IDLE on the cycle it reaches 1.
  - Exactly GAP dead cycles separate the output handshake from the next IDLE cycle.
  - With GAP==0, the next input can be accepted in the cycle after the output handshake. Sustained throughput is 1 packet per 2 cycles.
- Simultaneous valid:
  - Strict alternation while both channels stay valid.
  - A lone valid channel is always granted, regardless of last_grant.
- An input channel whose valid drops before the handshake is not accepted. No data is captured without a handshake.
- pkt_ready high while pkt_valid=0 is ignored.
- Reset mid-SEND or mid-GAP: the pending packet is discarded, pkt_valid drops asynchronously, and pkt_count clears. No partial packet is ever emitted.
- Destination is not checked. dest==SRC_ADDR is still emitted.

Test Plan:
- Filter only: filt_data=24'h030201, filt_dest=4'b0101, SRC_ADDR=0 → pkt_data=33'h0_5_0_030201 (type 0), pkt_valid from cycle N+1, pkt_count=1 after ready.
- Ifmap only: ifmap_data=9'b111_010_001, dest=4'b1010 → pkt_data[32]=1, [31:28]=1010, [23:9]=0, [8:0]=1_1101_0001.
- Both valid continuously, pkt_ready=1, GAP=0, 4 words each → output order F,I,F,I,F,I,F,I; a packet every 2 cycles; pkt_count=8.
- Backpressure: pkt_ready=0 for 5 cycles after valid → pkt_data stable, both readies 0; one handshake on release, no duplicate packet.
- GAP=3 → exactly 3 cycles with both readies 0 after the output handshake; the next input is accepted on the 4th cycle.
- Reset asserted while in SEND → pkt_valid=0 immediately and pkt_count=0; after release the first tie grants filter.

Source files
------------

// File: rtl/pe_pkt_gen.sv
// NoC packetizer: round-robin filter/ifmap source arbitration, 33-bit packet
// build with type/dest/src header, and a programmable post-send injection gap.
module pe_pkt_gen #(
    parameter int         WIDTH        = 33,
    parameter int         FILTER_WIDTH = 8,
    parameter int         IFMAP_WIDTH  = 1,
    parameter logic [3:0] SRC_ADDR     = 4'b0000,
    parameter int         GAP          = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      filt_valid,
    output logic                      filt_ready,
    input  logic [3*FILTER_WIDTH-1:0] filt_data,
    input  logic [3:0]                filt_dest,
    input  logic                      ifmap_valid,
    output logic                      ifmap_ready,
    input  logic [9*IFMAP_WIDTH-1:0]  ifmap_data,
    input  logic [3:0]                ifmap_dest,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [WIDTH-1:0]          pkt_data,
    output logic [15:0]               pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic [3:0] GAP_INIT = 4'(GAP);

    state_t           state, state_d;
    logic [3:0]       gap_cnt, gap_d;
    logic             last_ifmap, last_d;
    logic             valid_d;
    logic [WIDTH-1:0] data_d;
    logic [15:0]      count_d;
    logic [WIDTH-1:0] filt_pkt;
    logic [WIDTH-1:0] ifmap_pkt;

    assign filt_pkt  = WIDTH'({1'b0, filt_dest, SRC_ADDR, 24'(filt_data)});
    assign ifmap_pkt = WIDTH'({1'b1, ifmap_dest, SRC_ADDR, 24'(ifmap_data)});

    // Readies are only offered from IDLE and never while reset is held.
    always_comb begin
        filt_ready  = 1'b0;
        ifmap_ready = 1'b0;
        if (rst_n && state == ST_IDLE) begin
            filt_ready  = filt_valid & (~ifmap_valid | last_ifmap);
            ifmap_ready = ifmap_valid & (~filt_valid | ~last_ifmap);
        end
    end

    always_comb begin
        state_d = state;
        gap_d   = gap_cnt;
        last_d  = last_ifmap;
        valid_d = pkt_valid;
        data_d  = pkt_data;
        count_d = pkt_count;
        unique case (state)
            ST_IDLE: begin
                if (filt_ready) begin
                    data_d  = filt_pkt;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = ST_SEND;
                end else if (ifmap_ready) begin
                    data_d  = ifmap_pkt;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pkt_ready) begin
                    valid_d = 1'b0;
                    count_d = pkt_count + 16'd1;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gap_d   = 4'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gap_cnt    <= 4'd0;
            last_ifmap <= 1'b1;
            pkt_valid  <= 1'b0;
            pkt_data   <= '0;
            pkt_count  <= 16'd0;
        end else begin
            state      <= state_d;
            gap_cnt    <= gap_d;
            last_ifmap <= last_d;
            pkt_valid  <= valid_d;
            pkt_data   <= data_d;
            pkt_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_pe_pkt_gen.sv
// Bench for pe_pkt_gen: GAP=0 and GAP=3 instances share stimulus and are
// checked every cycle against a timestamp-based model plus literal vectors.
module tb_pe_pkt_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        filt_valid;
    logic [23:0] filt_data;
    logic [3:0]  filt_dest;
    logic        ifmap_valid;
    logic [8:0]  ifmap_data;
    logic [3:0]  ifmap_dest;
    logic        pkt_ready;

    logic        fr [2];
    logic        ir [2];
    logic        pv [2];
    logic [32:0] pd [2];
    logic [15:0] pc [2];

    always #5 clk = ~clk;

    pe_pkt_gen #(.GAP(0)) u_g0 (
        .clk(clk), .rst_n(rst_n),
        .filt_valid(filt_valid), .filt_ready(fr[0]),
        .filt_data(filt_data), .filt_dest(filt_dest),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ir[0]),
        .ifmap_data(ifmap_data), .ifmap_dest(ifmap_dest),
        .pkt_valid(pv[0]), .pkt_ready(pkt_ready),
        .pkt_data(pd[0]), .pkt_count(pc[0])
    );

    pe_pkt_gen #(.GAP(3)) u_g3 (
        .clk(clk), .rst_n(rst_n),
        .filt_valid(filt_valid), .filt_ready(fr[1]),
        .filt_data(filt_data), .filt_dest(filt_dest),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ir[1]),
        .ifmap_data(ifmap_data), .ifmap_dest(ifmap_dest),
        .pkt_valid(pv[1]), .pkt_ready(pkt_ready),
        .pkt_data(pd[1]), .pkt_count(pc[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: a packet is pending or not; inputs are accepted only when
    // nothing is pending and the current cycle has reached free_at.
    bit          pend [2];
    logic [32:0] mpkt [2];
    logic [15:0] mcnt [2];
    bit          mlast_if [2];
    int          free_at [2];
    int          last_out [2];
    int          last_delta [2];
    int          gapv [2] = '{0, 3};
    bit          types_q [$];
    int          outc_q [$];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_cycle();
        for (int i = 0; i < 2; i++) begin
            bit ef, ei, idle;
            ef = 1'b0;
            ei = 1'b0;
            if (!rst_n) begin
                pend[i]     = 1'b0;
                mcnt[i]     = 16'd0;
                mlast_if[i] = 1'b1;
                free_at[i]  = 0;
                chk($sformatf("g%0d_rst_valid", i), pv[i], 0);
                chk($sformatf("g%0d_rst_data", i), pd[i], 0);
                chk($sformatf("g%0d_rst_count", i), pc[i], 0);
                chk($sformatf("g%0d_rst_fr", i), fr[i], 0);
                chk($sformatf("g%0d_rst_ir", i), ir[i], 0);
            end else begin
                idle = !pend[i] && cyc >= free_at[i];
                if (idle) begin
                    ef = filt_valid && (!ifmap_valid || mlast_if[i]);
                    ei = ifmap_valid && (!filt_valid || !mlast_if[i]);
                end
                chk($sformatf("g%0d_filt_ready", i), fr[i], ef);
                chk($sformatf("g%0d_ifmap_ready", i), ir[i], ei);
                chk($sformatf("g%0d_pkt_valid", i), pv[i], pend[i]);
                chk($sformatf("g%0d_pkt_count", i), pc[i], mcnt[i]);
                if (pend[i])
                    chk($sformatf("g%0d_pkt_data", i), pd[i], mpkt[i]);
                if (ef) begin
                    mpkt[i] = {1'b0, filt_dest, 4'h0, filt_data};
                    pend[i] = 1'b1;
                    mlast_if[i] = 1'b0;
                    last_delta[i] = cyc - last_out[i];
                end else if (ei) begin
                    mpkt[i] = {1'b1, ifmap_dest, 4'h0, 15'h0, ifmap_data};
                    pend[i] = 1'b1;
                    mlast_if[i] = 1'b1;
                    last_delta[i] = cyc - last_out[i];
                end else if (pend[i] && pkt_ready) begin
                    mcnt[i] = mcnt[i] + 16'd1;
                    pend[i] = 1'b0;
                    free_at[i] = cyc + 1 + gapv[i];
                    last_out[i] = cyc;
                    if (i == 0) begin
                        types_q.push_back(mpkt[i][32]);
                        outc_q.push_back(cyc);
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        filt_valid = 1'b0;
        filt_data = '0;
        filt_dest = '0;
        ifmap_valid = 1'b0;
        ifmap_data = '0;
        ifmap_dest = '0;
        pkt_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_out[i] = 0;
            last_delta[i] = 0;
        end
        ticks(2);
        chk("reset_count", pc[0], 16'd0);
        rst_n = 1'b1;
        ticks(2);

        filt_data = 24'h030201;
        filt_dest = 4'b0101;
        filt_valid = 1'b1;
        tick();
        chk("filt_latency", pv[0], 1);
        chk("filt_pkt", pd[0], 33'h050030201);
        filt_data = 24'hAABBCC;
        ticks(5);
        chk("bp_hold", pd[0], 33'h050030201);
        chk("bp_fr", fr[0], 0);
        pkt_ready = 1'b1;
        filt_valid = 1'b0;
        tick();
        pkt_ready = 1'b0;
        chk("cnt1", pc[0], 16'd1);
        chk("valid_drop", pv[0], 0);
        tick();
        chk("no_dup", pc[0], 16'd1);
        ticks(5);

        ifmap_data = 9'b111_010_001;
        ifmap_dest = 4'b1010;
        ifmap_valid = 1'b1;
        tick();
        ifmap_valid = 1'b0;
        chk("ifmap_pkt", pd[0], 33'h1A00001D1);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        chk("cnt2", pc[0], 16'd2);
        ticks(5);

        types_q.delete();
        outc_q.delete();
        filt_data = 24'h112233;
        filt_dest = 4'h6;
        ifmap_data = 9'h0AA;
        ifmap_dest = 4'h9;
        filt_valid = 1'b1;
        ifmap_valid = 1'b1;
        pkt_ready = 1'b1;
        ticks(16);
        filt_valid = 1'b0;
        ifmap_valid = 1'b0;
        chk("tp_count", pc[0], 16'd10);
        chk("tp_n", types_q.size(), 8);
        for (int k = 0; k < types_q.size(); k++)
            chk($sformatf("tp_type%0d", k), types_q[k], k % 2);
        for (int k = 1; k < outc_q.size(); k++)
            chk($sformatf("tp_space%0d", k), outc_q[k] - outc_q[k-1], 2);
        chk("tp_delta", last_delta[0], 1);
        ticks(8);
        pkt_ready = 1'b0;
        tick();

        filt_data = 24'h445566;
        filt_dest = 4'h3;
        filt_valid = 1'b1;
        pkt_ready = 1'b1;
        ticks(12);
        filt_valid = 1'b0;
        chk("gap3_delta", last_delta[1], 4);
        chk("gap0_delta", last_delta[0], 1);
        ticks(6);
        pkt_ready = 1'b0;

        filt_valid = 1'b1;
        tick();
        tick();
        chk("pre_rst_valid", pv[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_v0", pv[0], 0);
        chk("rst_async_v3", pv[1], 0);
        chk("rst_async_c0", pc[0], 16'd0);
        chk("rst_async_c3", pc[1], 16'd0);
        tick();
        rst_n = 1'b1;
        ifmap_valid = 1'b1;
        tick();
        filt_valid = 1'b0;
        ifmap_valid = 1'b0;
        chk("post_rst_grant0", pd[0][32], 0);
        chk("post_rst_grant3", pd[1][32], 0);
        pkt_ready = 1'b1;
        tick();
        chk("post_rst_cnt", pc[0], 16'd1);
        pkt_ready = 1'b0;
        ticks(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
